// File: rtl/output_buffer_pkg.sv
// Shared configuration for the output buffer: array geometry, datapath widths,
// tile height and the default FIFO depth, plus the row types built from them.
package Config;

    localparam int sys_cols   = 4;
    localparam int P_BITWIDTH = 32;
    localparam int A_BITWIDTH = 8;
    localparam int A_rows     = 8;
    localparam int OB_DEPTH   = 4;

    localparam int SHIFT_W = $clog2(P_BITWIDTH);

    typedef logic [sys_cols-1:0][P_BITWIDTH-1:0] psum_row_t;
    typedef logic [sys_cols-1:0][A_BITWIDTH-1:0] act_row_t;

endpackage

// File: rtl/output_buffer_requant.sv
// Per-column requantization: arithmetic shift (floor), optional ReLU, then
// saturation of the wide partial sum into the signed activation range.
module requant
    import Config::*;
(
    input  logic [P_BITWIDTH-1:0] in_data,
    input  logic [SHIFT_W-1:0]    shift,
    input  logic                  relu_en,
    output logic [A_BITWIDTH-1:0] out_data
);

    localparam logic signed [P_BITWIDTH-1:0] SAT_MAX = P_BITWIDTH'((2 ** (A_BITWIDTH - 1)) - 1);
    localparam logic signed [P_BITWIDTH-1:0] SAT_MIN = ~SAT_MAX;

    logic signed [P_BITWIDTH-1:0] shifted;
    logic signed [P_BITWIDTH-1:0] clamped;

    always_comb begin
        shifted = $signed(in_data) >>> shift;
        clamped = shifted;
        if (relu_en && (shifted < 0)) begin
            clamped = '0;
        end
        if (clamped > SAT_MAX) begin
            out_data = SAT_MAX[A_BITWIDTH-1:0];
        end else if (clamped < SAT_MIN) begin
            out_data = SAT_MIN[A_BITWIDTH-1:0];
        end else begin
            out_data = clamped[A_BITWIDTH-1:0];
        end
    end

endmodule

// File: rtl/output_buffer.sv
// Deskews systolic column outputs, requantizes each aligned row and queues it
// in a small FIFO; counts accepted rows to flag the end of each tile.
module output_buffer
    import Config::*;
#(
    parameter int DEPTH = OB_DEPTH
)
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_valid,
    input  psum_row_t                 of_data,
    input  logic [SHIFT_W-1:0]        shift,
    input  logic                      relu_en,
    input  logic                      o_ready,
    output logic                      o_valid,
    output act_row_t                  o_data,
    output logic [$clog2(DEPTH):0]    count,
    output logic                      full,
    output logic                      overflow,
    output logic                      tile_done
);

    localparam int AW   = $clog2(DEPTH);
    localparam int CW   = AW + 1;
    localparam int RW   = (A_rows > 1) ? $clog2(A_rows) : 1;
    localparam int VLEN = sys_cols - 1;

    psum_row_t aligned;
    act_row_t  row_req;

    // Column j arrives j cycles after column 0, so it needs sys_cols-1-j stages.
    for (genvar j = 0; j < sys_cols; j++) begin : g_col
        localparam int D = sys_cols - 1 - j;
        if (D == 0) begin : g_direct
            assign aligned[j] = of_data[j];
        end else begin : g_dly
            logic [D-1:0][P_BITWIDTH-1:0] dly_q;
            logic [D-1:0][P_BITWIDTH-1:0] dly_d;

            always_comb begin
                dly_d    = dly_q;
                dly_d[0] = of_data[j];
                for (int k = 1; k < D; k++) begin
                    dly_d[k] = dly_q[k-1];
                end
            end

            always_ff @(posedge clk) begin
                dly_q <= dly_d;
            end

            assign aligned[j] = dly_q[D-1];
        end

        requant u_requant (
            .in_data  (aligned[j]),
            .shift    (shift),
            .relu_en  (relu_en),
            .out_data (row_req[j])
        );
    end

    logic [VLEN-1:0] vld_q;
    logic [VLEN-1:0] vld_d;
    logic            row_valid;

    always_comb begin
        vld_d    = vld_q;
        vld_d[0] = i_valid;
        for (int k = 1; k < VLEN; k++) begin
            vld_d[k] = vld_q[k-1];
        end
    end

    assign row_valid = vld_q[VLEN-1];

    act_row_t        mem_q [DEPTH];
    logic [AW-1:0]   wptr_q, wptr_d;
    logic [AW-1:0]   rptr_q, rptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            overflow_q, overflow_d;
    logic [RW-1:0]   row_cnt_q, row_cnt_d;
    logic            tile_done_q, tile_done_d;
    logic            pop;
    logic            push_ok;
    logic            is_full;

    assign is_full = (count_q == CW'(DEPTH));

    always_comb begin
        pop         = (count_q != '0) && o_ready;
        // A full FIFO still takes the row when the head leaves in the same cycle.
        push_ok     = row_valid && (!is_full || pop);
        wptr_d      = push_ok ? wptr_q + 1'b1 : wptr_q;
        rptr_d      = pop ? rptr_q + 1'b1 : rptr_q;
        count_d     = count_q;
        if (push_ok && !pop) begin
            count_d = count_q + 1'b1;
        end else if (!push_ok && pop) begin
            count_d = count_q - 1'b1;
        end
        overflow_d  = overflow_q || (row_valid && !push_ok);
        row_cnt_d   = row_cnt_q;
        tile_done_d = 1'b0;
        if (push_ok) begin
            if (row_cnt_q == RW'(A_rows - 1)) begin
                row_cnt_d   = '0;
                tile_done_d = 1'b1;
            end else begin
                row_cnt_d = row_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            vld_q       <= '0;
            wptr_q      <= '0;
            rptr_q      <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            row_cnt_q   <= '0;
            tile_done_q <= 1'b0;
        end else begin
            vld_q       <= vld_d;
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            row_cnt_q   <= row_cnt_d;
            tile_done_q <= tile_done_d;
        end
    end

    // Storage has no reset so it maps onto distributed RAM.
    always_ff @(posedge clk) begin
        if (rst && push_ok) begin
            mem_q[wptr_q] <= row_req;
        end
    end

    assign o_valid   = (count_q != '0);
    assign o_data    = o_valid ? mem_q[rptr_q] : '0;
    assign count     = count_q;
    assign full      = is_full;
    assign overflow  = overflow_q;
    assign tile_done = tile_done_q;

endmodule

// File: tb/tb_output_buffer.sv
// Bench for output_buffer: cycle driver with deskewed row bursts, a reference
// requant model feeding an expected-row queue, a vector table and corner sequences.
module tb_output_buffer;
    import Config::*;

    localparam int DEPTH = 4;

    logic                      clk;
    logic                      rst;
    logic                      i_valid;
    logic [3:0][31:0]          of_data;
    logic [4:0]                shift;
    logic                      relu_en;
    logic                      o_ready;
    logic                      o_valid;
    logic [3:0][7:0]           o_data;
    logic [2:0]                count;
    logic                      full;
    logic                      overflow;
    logic                      tile_done;

    output_buffer #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .i_valid   (i_valid),
        .of_data   (of_data),
        .shift     (shift),
        .relu_en   (relu_en),
        .o_ready   (o_ready),
        .o_valid   (o_valid),
        .o_data    (o_data),
        .count     (count),
        .full      (full),
        .overflow  (overflow),
        .tile_done (tile_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [3:0][31:0] v;
        int               sh;
        bit               relu;
        logic [3:0][7:0]  e;
    } vec_t;

    int checks = 0;
    int errors = 0;

    logic [31:0]      exp_q[$];
    bit               ovf_model;
    int               tile_cnt;
    bit               tile_next;
    int               tile_pulses;

    logic [3:0][31:0] b_data [16];
    int               b_sh   [16];
    bit               b_relu [16];
    int               b_n;
    int               b_c;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0][31:0] pk32(input int a0, input int a1, input int a2, input int a3);
        logic [3:0][31:0] r;
        r[0] = a0; r[1] = a1; r[2] = a2; r[3] = a3;
        return r;
    endfunction

    function automatic logic [3:0][7:0] pk8(input int a0, input int a1, input int a2, input int a3);
        logic [3:0][7:0] r;
        r[0] = 8'(a0); r[1] = 8'(a1); r[2] = 8'(a2); r[3] = 8'(a3);
        return r;
    endfunction

    function automatic logic [7:0] rq(input logic [31:0] x, input int sh, input bit relu);
        longint v;
        v = longint'($signed(x));
        v = v >>> sh;
        if (relu && v < 0) v = 0;
        if (v > 127) v = 127;
        if (v < -128) v = -128;
        return 8'(v);
    endfunction

    function automatic logic [31:0] rq_row(input logic [3:0][31:0] x, input int sh, input bit relu);
        logic [3:0][7:0] r;
        for (int j = 0; j < 4; j++) r[j] = rq(x[j], sh, relu);
        return r;
    endfunction

    task automatic model_clear();
        exp_q.delete();
        ovf_model = 1'b0;
        tile_cnt  = 0;
        tile_next = 1'b0;
    endtask

    // One clock cycle: check outputs against the model, drive inputs, advance model.
    task automatic cycle(input bit rdy);
        int  ra;
        int  sz;
        bit  pop;
        chk("o_valid", 32'(o_valid), 32'(exp_q.size() != 0));
        chk("count", 32'(count), 32'(exp_q.size()));
        chk("full", 32'(full), 32'(exp_q.size() == DEPTH));
        chk("overflow", 32'(overflow), 32'(ovf_model));
        chk("tile_done", 32'(tile_done), 32'(tile_next));
        if (tile_done) tile_pulses++;
        tile_next = 1'b0;

        o_ready = rdy;
        for (int j = 0; j < 4; j++) begin
            if (b_c >= 0 && (b_c - j) >= 0 && (b_c - j) < b_n) of_data[j] = b_data[b_c - j][j];
            else of_data[j] = $urandom();
        end
        i_valid = (b_c >= 0 && b_c < b_n);
        ra = (b_c >= 0) ? b_c - 3 : -1;
        if (ra >= 0 && ra < b_n) begin
            shift   = 5'(b_sh[ra]);
            relu_en = b_relu[ra];
        end else begin
            shift   = 5'($urandom_range(0, 31));
            relu_en = 1'($urandom_range(0, 1));
        end

        sz  = exp_q.size();
        pop = (sz != 0) && rdy;
        if (pop) begin
            chk("o_data_pop", o_data, exp_q[0]);
            void'(exp_q.pop_front());
        end
        if (ra >= 0 && ra < b_n) begin
            if (sz < DEPTH || pop) begin
                exp_q.push_back(rq_row(b_data[ra], b_sh[ra], b_relu[ra]));
                if (tile_cnt == A_rows - 1) begin
                    tile_cnt  = 0;
                    tile_next = 1'b1;
                end else begin
                    tile_cnt++;
                end
            end else begin
                ovf_model = 1'b1;
            end
        end

        @(posedge clk);
        #1;
        if (b_c >= 0) begin
            b_c++;
            if (b_c >= b_n + 3) b_c = -1;
        end
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) cycle(rdy);
    endtask

    task automatic fill_random(input int n, input bit rand_cfg);
        for (int r = 0; r < n; r++) begin
            for (int j = 0; j < 4; j++) b_data[r][j] = $urandom();
            b_sh[r]   = rand_cfg ? $urandom_range(0, 31) : $urandom_range(20, 26);
            b_relu[r] = rand_cfg ? 1'($urandom_range(0, 1)) : 1'b0;
        end
    endtask

    // mode: 0 never ready, 1 always, 2 random, 3 only on the last row's aligned cycle
    task automatic run_burst(input int n, input int mode);
        int guard;
        bit rdy;
        b_n   = n;
        b_c   = 0;
        guard = 0;
        while (b_c != -1 && guard < 64) begin
            case (mode)
                0:       rdy = 1'b0;
                1:       rdy = 1'b1;
                2:       rdy = 1'($urandom_range(0, 1));
                default: rdy = (b_c == n + 2);
            endcase
            cycle(rdy);
            guard++;
        end
        if (guard >= 64) chk("burst_timeout", 32'(guard), 32'd0);
    endtask

    task automatic do_reset();
        rst     = 1'b0;
        b_c     = -1;
        i_valid = 1'b0;
        o_ready = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        model_clear();
    endtask

    vec_t             vecs [7];
    logic [31:0]      head_exp;

    initial begin
        rst         = 1'b0;
        i_valid     = 1'b0;
        of_data     = '0;
        shift       = '0;
        relu_en     = 1'b0;
        o_ready     = 1'b0;
        b_c         = -1;
        b_n         = 0;
        tile_pulses = 0;
        model_clear();

        vecs[0] = '{pk32(100, 200, 300, 400), 2, 1'b0, pk8(25, 50, 75, 100)};
        vecs[1] = '{pk32(-1000, 1000, -3, 5), 0, 1'b0, pk8(-128, 127, -3, 5)};
        vecs[2] = '{pk32(-1000, 1000, -3, 5), 0, 1'b1, pk8(0, 127, 0, 5)};
        vecs[3] = '{pk32(-7, 7, -1, -256), 1, 1'b0, pk8(-4, 3, -1, -128)};
        vecs[4] = '{pk32(32'h7fffffff, 32'h80000000, 1024, -1024), 3, 1'b0, pk8(127, -128, 127, -128)};
        vecs[5] = '{pk32(255, -129, 2047, -2049), 4, 1'b1, pk8(15, 0, 127, 0)};
        vecs[6] = '{pk32(-1, 32'h7fffffff, -5, 1), 31, 1'b0, pk8(-1, 0, -1, 0)};

        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        chk("rst_o_valid", 32'(o_valid), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_tile_done", 32'(tile_done), 32'd0);
        chk("rst_o_data", o_data, 32'd0);
        idle(3, 1'b1);

        // Table: one row each, visible four cycles after i_valid
        for (int i = 0; i < 7; i++) begin
            b_data[0] = vecs[i].v;
            b_sh[0]   = vecs[i].sh;
            b_relu[0] = vecs[i].relu;
            run_burst(1, 0);
            chk($sformatf("vec%0d_o_valid", i), 32'(o_valid), 32'd1);
            chk($sformatf("vec%0d_o_data", i), o_data, vecs[i].e);
            chk($sformatf("vec%0d_count", i), 32'(count), 32'd1);
            idle(2, 1'b1);
        end

        // Push into an empty FIFO while ready is high
        fill_random(1, 1'b1);
        run_burst(1, 1);
        chk("empty_pushpop_o_valid", 32'(o_valid), 32'd1);
        idle(2, 1'b1);

        // Back-pressure: five rows, the fifth is dropped, then drain in order
        do_reset();
        fill_random(5, 1'b0);
        run_burst(5, 0);
        chk("bp_full", 32'(full), 32'd1);
        chk("bp_count", 32'(count), 32'd4);
        chk("bp_overflow", 32'(overflow), 32'd1);
        idle(6, 1'b1);
        chk("bp_drained", 32'(count), 32'd0);

        // Full FIFO with a pop in the same cycle as a push
        do_reset();
        fill_random(4, 1'b0);
        run_burst(4, 0);
        head_exp = rq_row(b_data[1], b_sh[1], b_relu[1]);
        fill_random(1, 1'b0);
        run_burst(1, 3);
        chk("fullpop_count", 32'(count), 32'd4);
        chk("fullpop_overflow", 32'(overflow), 32'd0);
        chk("fullpop_head", o_data, head_exp);
        idle(6, 1'b1);

        // Reset two cycles after i_valid discards the row in flight
        do_reset();
        fill_random(1, 1'b1);
        b_n = 1;
        b_c = 0;
        cycle(1'b0);
        cycle(1'b0);
        do_reset();
        chk("midrst_o_valid", 32'(o_valid), 32'd0);
        chk("midrst_count", 32'(count), 32'd0);
        idle(6, 1'b0);
        chk("midrst_no_row", 32'(count), 32'd0);

        // Tile: A_rows rows with ready high give exactly one pulse
        do_reset();
        tile_pulses = 0;
        fill_random(A_rows, 1'b1);
        run_burst(A_rows, 1);
        idle(4, 1'b1);
        chk("tile_pulses", 32'(tile_pulses), 32'd1);

        // Random traffic with random back-pressure
        for (int k = 0; k < 4; k++) begin
            fill_random(10, 1'b1);
            run_burst(10, 2);
            idle($urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end
        idle(8, 1'b1);
        chk("final_empty", 32'(count), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
